// File: rtl/wdt_pkg.sv
// rtl/wdt_pkg.sv - shared offsets, keys, bit indices and FSM states for the watchdog
package wdt_pkg;

  // Byte offsets within the 32-byte window
  localparam logic [4:0] OFS_CTRL   = 5'h00;
  localparam logic [4:0] OFS_LOAD   = 5'h04;
  localparam logic [4:0] OFS_COUNT  = 5'h08;
  localparam logic [4:0] OFS_KICK   = 5'h0C;
  localparam logic [4:0] OFS_STATUS = 5'h10;

  localparam logic [31:0] KICK_KEY = 32'h5A5A_A5A5;

  // func3 encoding of a full-word access
  localparam logic [2:0] OP_WORD = 3'b010;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_RST_EN = 2;
  localparam int CTRL_PS_LO  = 8;
  localparam int CTRL_PS_HI  = 15;
  localparam int CTRL_LOCK   = 31;

  // STATUS bit positions
  localparam int ST_PEND = 0;
  localparam int ST_BITE = 1;
  localparam int ST_LOCK = 2;
  localparam int ST_ERR  = 3;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    WARN = 2'd2,
    BITE = 2'd3
  } wdt_state_t;

  // A zero reload would never expire, so it behaves as one
  function automatic logic [31:0] reload_value(input logic [31:0] v);
    return (v == 32'h0) ? 32'h1 : v;
  endfunction

endpackage

// File: rtl/wdt_prescaler.sv
// rtl/wdt_prescaler.sv - 8-bit clock divider producing a one-cycle tick every prescale+1 cycles
module wdt_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] cnt;

  // >= keeps the divider from running the full 8-bit range if prescale shrinks mid-count
  assign tick = en & (cnt >= prescale);

  // Divider count: cleared on restart, wraps on tick, holds while disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en) begin
      cnt <= tick ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/wdt_mmio.sv
// rtl/wdt_mmio.sv - memory-mapped watchdog with IRQ then reset-pulse expiry; WDT_LOCK_EN adds CTRL/LOAD lock
module wdt_mmio
  import wdt_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          RST_PULSE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_en,
  input  logic        r_en,
  input  logic [2:0]  op_sel,
  input  logic [31:0] addr,
  input  logic [31:0] data_w,
  output logic [31:0] data_r,
  output logic        wdt_irq,
  output logic        wdt_reset
);

  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  logic          en;
  logic          irq_en;
  logic          rst_en;
  logic [7:0]    prescale;
  logic [31:0]   load_q;
  logic [31:0]   count;
  logic          pend;
  logic          bite_st;
  logic          err;
  logic          lock;
  wdt_state_t    state;
  logic [PW-1:0] pulse_cnt;
  logic          tick;

  logic        hit;
  logic        word_op;
  logic        wr_any;
  logic        wr_ok;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_kick;
  logic        wr_status;
  logic        ctrl_ok;
  logic        load_ok;
  logic        lock_err;
  logic        en_rise;
  logic        en_fall;
  logic        kick_good;
  logic        kick_bad;
  logic        running;
  logic [31:0] reload;

  // Writes are dropped entirely while the reset pulse is being generated
  assign hit       = (addr[31:5] == BASE_ADDR[31:5]) && (addr[1:0] == 2'b00);
  assign word_op   = (op_sel == OP_WORD);
  assign wr_any    = w_en & hit & (state != BITE);
  assign wr_ok     = wr_any & word_op;
  assign wr_ctrl   = wr_ok & (addr[4:0] == OFS_CTRL);
  assign wr_load   = wr_ok & (addr[4:0] == OFS_LOAD);
  assign wr_kick   = wr_ok & (addr[4:0] == OFS_KICK);
  assign wr_status = wr_ok & (addr[4:0] == OFS_STATUS);
  assign ctrl_ok   = wr_ctrl & ~lock;
  assign load_ok   = wr_load & ~lock;
  assign lock_err  = lock & (wr_ctrl | wr_load);
  assign en_rise   = ctrl_ok & data_w[CTRL_EN] & ~en;
  assign en_fall   = ctrl_ok & ~data_w[CTRL_EN] & en;
  assign kick_good = wr_kick & (data_w == KICK_KEY);
  assign kick_bad  = wr_kick & (data_w != KICK_KEY);
  assign running   = (state == RUN) || (state == WARN);
  assign reload    = reload_value(load_q);

  assign wdt_irq = pend & irq_en;

`ifdef WDT_LOCK_EN
  // LOCK is sticky: once set by software only the block reset clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock <= 1'b0;
    end else if (ctrl_ok && data_w[CTRL_LOCK]) begin
      lock <= 1'b1;
    end
  end
`else
  assign lock = 1'b0;
`endif

  // Prescaler freezes on the disabling write so a later enable resumes cleanly
  wdt_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (running & ~en_fall),
    .clr      (en_rise | kick_good),
    .prescale (prescale),
    .tick     (tick)
  );

  // Combinational load data; misses, non-word accesses and write-only regs read 0
  always_comb begin
    data_r = 32'h0;
    if (r_en && hit && word_op) begin
      case (addr[4:0])
        OFS_CTRL:   data_r = {16'h0, prescale, 5'b0, rst_en, irq_en, en};
        OFS_LOAD:   data_r = load_q;
        OFS_COUNT:  data_r = count;
        OFS_STATUS: data_r = {28'h0, err, lock, bite_st, pend};
        default:    data_r = 32'h0;
      endcase
    end
  end

  // Register file, down-counter and expiry FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en        <= 1'b0;
      irq_en    <= 1'b0;
      rst_en    <= 1'b0;
      prescale  <= 8'h0;
      load_q    <= 32'hFFFF_FFFF;
      count     <= 32'h0;
      pend      <= 1'b0;
      bite_st   <= 1'b0;
      err       <= 1'b0;
      state     <= OFF;
      pulse_cnt <= '0;
      wdt_reset <= 1'b0;
    end else begin
      if (ctrl_ok) begin
        en       <= data_w[CTRL_EN];
        irq_en   <= data_w[CTRL_IRQ_EN];
        rst_en   <= data_w[CTRL_RST_EN];
        prescale <= data_w[CTRL_PS_HI:CTRL_PS_LO];
      end
      if (load_ok) begin
        load_q <= data_w;
      end
      if (wr_status) begin
        if (data_w[ST_PEND]) pend    <= 1'b0;
        if (data_w[ST_BITE]) bite_st <= 1'b0;
        if (data_w[ST_ERR])  err     <= 1'b0;
      end
      if ((wr_any && !word_op) || lock_err) begin
        err <= 1'b1;
      end

      // PEND set below comes after the W1C above so a coincident expiry keeps it set
      case (state)
        OFF: begin
          if (en_rise) begin
            count <= reload;
            state <= RUN;
          end else if (kick_good) begin
            count <= reload;
          end
        end
        RUN, WARN: begin
          if (en_fall) begin
            state <= OFF;
          end else if (kick_bad && rst_en) begin
            state     <= BITE;
            wdt_reset <= 1'b1;
            pulse_cnt <= PW'(RST_PULSE - 1);
          end else if (kick_good) begin
            count <= reload;
            state <= RUN;
          end else if (tick) begin
            if (count == 32'h1) begin
              if (state == RUN) begin
                pend  <= 1'b1;
                count <= reload;
                state <= WARN;
              end else if (rst_en) begin
                state     <= BITE;
                wdt_reset <= 1'b1;
                pulse_cnt <= PW'(RST_PULSE - 1);
              end else begin
                count <= reload;
              end
            end else begin
              count <= count - 32'h1;
            end
          end
        end
        BITE: begin
          if (pulse_cnt == '0) begin
            wdt_reset <= 1'b0;
            bite_st   <= 1'b1;
            en        <= 1'b0;
            state     <= OFF;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end
        default: state <= OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_wdt_mmio.sv
// tb/tb_wdt_mmio.sv - self-checking bench for wdt_mmio against an arithmetic timing model
module tb_wdt_mmio;

  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam int          PULSE = 4;
  localparam logic [31:0] KEY   = 32'h5A5A_A5A5;
  localparam logic [7:0]  A_CTRL   = 8'h00;
  localparam logic [7:0]  A_LOAD   = 8'h04;
  localparam logic [7:0]  A_COUNT  = 8'h08;
  localparam logic [7:0]  A_KICK   = 8'h0C;
  localparam logic [7:0]  A_STATUS = 8'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        w_en = 1'b0;
  logic        r_en = 1'b0;
  logic [2:0]  op_sel = 3'b010;
  logic [31:0] addr = 32'h0;
  logic [31:0] data_w = 32'h0;
  logic [31:0] data_r;
  logic        wdt_irq;
  logic        wdt_reset;

  int checks = 0;
  int errors = 0;

  wdt_mmio #(.BASE_ADDR(BASE), .RST_PULSE(PULSE)) dut (
    .clk       (clk),
    .rst       (rst),
    .w_en      (w_en),
    .r_en      (r_en),
    .op_sel    (op_sel),
    .addr      (addr),
    .data_w    (data_w),
    .data_r    (data_r),
    .wdt_irq   (wdt_irq),
    .wdt_reset (wdt_reset)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One store, consuming exactly one rising edge
  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [2:0] op = 3'b010);
    addr = BASE + 32'(off);
    data_w = d;
    op_sel = op;
    w_en = 1'b1;
    @(posedge clk);
    #1;
    w_en = 1'b0;
    op_sel = 3'b010;
  endtask

  // Combinational load sampled inside the current cycle
  task automatic rd(input logic [7:0] off, output logic [31:0] d);
    addr = BASE + 32'(off);
    op_sel = 3'b010;
    r_en = 1'b1;
    #1;
    d = data_r;
    r_en = 1'b0;
  endtask

  // Edges until the chosen output is seen high (0 = irq, 1 = reset)
  task automatic wait_rise(input bit which, input int limit, output int k);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!(which ? wdt_reset : wdt_irq) && k < limit);
  endtask

  task automatic pulse_width(output int w);
    w = 0;
    while (wdt_reset && w < 50) begin
      w++;
      @(posedge clk);
      #1;
    end
  endtask

  // Model: with LOAD n (0 acts as 1) and PRESCALE p an expiry takes n*(p+1) cycles from a restart
  function automatic int expiry_cycles(input int p, input int n);
    return ((n == 0) ? 1 : n) * (p + 1);
  endfunction

  initial begin
    logic [31:0] d;
    logic [31:0] load_model;
    int k;
    int w;

    // Reset state
    cyc(3);
    rst = 1'b1;
    cyc(1);
    chk("rst_data_r_idle", data_r, 32'h0);
    chk("rst_irq", 32'(wdt_irq), 32'h0);
    chk("rst_reset", 32'(wdt_reset), 32'h0);
    rd(A_CTRL, d);   chk("rst_ctrl", d, 32'h0);
    rd(A_LOAD, d);   chk("rst_load", d, 32'hFFFF_FFFF);
    rd(A_COUNT, d);  chk("rst_count", d, 32'h0);
    rd(A_STATUS, d); chk("rst_status", d, 32'h0);
    rd(A_KICK, d);   chk("rst_kick", d, 32'h0);

    // First expiry with PRESCALE 0, LOAD 3
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h0000_0003);
    wait_rise(1'b0, 200, k);
    chk("first_irq_delay", k, 32'd3);
    rd(A_STATUS, d); chk("first_status", d, 32'h1);
    rd(A_COUNT, d);  chk("first_count", d, 32'd3);
    wr(A_CTRL, 32'h0);
    cyc(5);
    rd(A_COUNT, d);  chk("off_count_hold", d, 32'd3);
    chk("off_irq_masked", 32'(wdt_irq), 32'h0);
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, d); chk("pend_w1c", d, 32'h0);

    // Kick sequences then full bite; iteration 0 uses PRESCALE 1, LOAD 4, kicks every 6
    for (int it = 0; it < 6; it++) begin
      int p, n, t, nk, g;
      logic [31:0] cv;
      if (it == 0) begin
        p = 1; n = 4; nk = 3;
      end else begin
        p = int'($urandom_range(0, 3));
        n = int'($urandom_range(0, 5));
        nk = int'($urandom_range(0, 3));
      end
      t = expiry_cycles(p, n);
      cv = (32'(p) << 8) | 32'h7;
      wr(A_LOAD, 32'(n));
      wr(A_CTRL, cv);
      rd(A_CTRL, d); chk("loop_ctrl_rd", d, cv);
      for (int j = 0; j < nk; j++) begin
        g = (it == 0) ? 6 : int'($urandom_range(1, t));
        cyc(g - 1);
        wr(A_KICK, KEY);
        chk("kick_irq_low", 32'(wdt_irq), 32'h0);
      end
      wait_rise(1'b0, 300, k);
      chk("irq_delay", k, 32'(t));
      rd(A_STATUS, d); chk("warn_status", d, 32'h1);
      wait_rise(1'b1, 300, k);
      chk("reset_delay", k, 32'(t));
      pulse_width(w);
      chk("reset_width", w, 32'(PULSE));
      rd(A_STATUS, d); chk("bite_status", d, 32'h3);
      rd(A_CTRL, d);   chk("bite_ctrl_en_clr", d, cv & ~32'h1);
      chk("bite_irq_held", 32'(wdt_irq), 32'h1);
      wr(A_STATUS, 32'hB);
      rd(A_STATUS, d); chk("bite_w1c", d, 32'h0);
      chk("irq_cleared", 32'(wdt_irq), 32'h0);
    end

    // Bad kick goes straight to BITE
    wr(A_LOAD, 32'd100);
    wr(A_CTRL, 32'h0000_0005);
    wr(A_KICK, 32'h1234_5678);
    chk("badkick_reset_now", 32'(wdt_reset), 32'h1);
    pulse_width(w);
    chk("badkick_width", w, 32'(PULSE));
    rd(A_STATUS, d); chk("badkick_status", d, 32'h2);
    rd(A_CTRL, d);   chk("badkick_ctrl", d, 32'h4);
    wr(A_STATUS, 32'h2);

    // Access errors and decode misses
    load_model = 32'd100;
    wr(A_LOAD, 32'hDEAD_BEEF, 3'b000);
    rd(A_LOAD, d);   chk("byte_store_ignored", d, load_model);
    rd(A_STATUS, d); chk("byte_store_err", d, 32'h8);
    rd(8'h20, d);    chk("read_out_of_window", d, 32'h0);
    addr = BASE + 32'h5;
    r_en = 1'b1;
    #1;
    chk("read_misaligned", data_r, 32'h0);
    r_en = 1'b0;
    wr(A_STATUS, 32'h8);
    rd(A_STATUS, d); chk("err_w1c", d, 32'h0);

    // Random register readback with the counter kept disabled
    for (int i = 0; i < 6; i++) begin
      logic [31:0] v;
      v = $urandom();
      wr(A_LOAD, v);
      rd(A_LOAD, d); chk("rand_load", d, v);
      v = $urandom() & 32'h7FFF_FFFE;
      wr(A_CTRL, v);
      rd(A_CTRL, d); chk("rand_ctrl", d, v & 32'h0000_FF06);
    end

    // Asynchronous reset in the middle of a reset pulse
    wr(A_CTRL, 32'h0000_0005);
    wr(A_KICK, 32'h0);
    cyc(1);
    rst = 1'b0;
    #1;
    chk("async_reset_drop", 32'(wdt_reset), 32'h0);
    cyc(2);
    rst = 1'b1;
    rd(A_CTRL, d);   chk("async_ctrl", d, 32'h0);
    rd(A_LOAD, d);   chk("async_load", d, 32'hFFFF_FFFF);
    rd(A_COUNT, d);  chk("async_count", d, 32'h0);
    rd(A_STATUS, d); chk("async_status", d, 32'h0);

    // Lock bit behaviour
    wr(A_CTRL, 32'h8000_0001);
    wr(A_CTRL, 32'h0);
`ifdef WDT_LOCK_EN
    rd(A_CTRL, d);   chk("lock_ctrl_held", d, 32'h1);
    rd(A_STATUS, d); chk("lock_status", d, 32'hC);
`else
    rd(A_CTRL, d);   chk("nolock_ctrl", d, 32'h0);
    rd(A_STATUS, d); chk("nolock_status", d, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
